// File: rtl/territory_scanner_if.sv
// territory_scanner_if: control handshake and RAM read bus of the scanner.
// Signals: start/busy/done (request and status), rd_address/rd_q (RAM port).
interface territory_scanner_if;
    logic        start;
    logic        busy;
    logic        done;
    logic [14:0] rd_address;
    logic [2:0]  rd_q;

    // Scanner side: takes requests, drives the RAM read address.
    modport master (
        input  start,
        input  rd_q,
        output busy,
        output done,
        output rd_address
    );

    // Requester / RAM side.
    modport slave (
        output start,
        output rd_q,
        input  busy,
        input  done,
        input  rd_address
    );
endinterface

// File: rtl/territory_scanner.sv
// territory_scanner: sweeps the 160x120 territory RAM once per request,
// tallies the cells owned by each of four players and publishes a winner.
// Ports:
//   CLOCK_50  system clock
//   resetn    asynchronous active-low reset
//   bus       master side of territory_scanner_if
//             (start, busy, done, rd_address, rd_q)
//   p1_count..p4_count  published per-player cell counts
//   winner    index of the strictly leading player, ties to the lowest
module territory_scanner #(
    parameter int X_MAX      = 159,
    parameter int Y_MAX      = 119,
    parameter int RD_LATENCY = 1
) (
    input  logic                       CLOCK_50,
    input  logic                       resetn,
    territory_scanner_if.master        bus,
    output logic [14:0]                p1_count,
    output logic [14:0]                p2_count,
    output logic [14:0]                p3_count,
    output logic [14:0]                p4_count,
    output logic [1:0]                 winner
);

    localparam logic [7:0] XL = 8'(X_MAX);
    localparam logic [6:0] YL = 7'(Y_MAX);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SCAN,
        S_DRAIN,
        S_PUBLISH
    } state_t;

    state_t      r_state;
    state_t      w_state_next;

    logic [7:0]  r_x;
    logic [6:0]  r_y;
    logic        r_skip;
    logic [14:0] r_acc [4];
    logic [14:0] r_cnt [4];
    logic [1:0]  r_winner;
    logic        r_done;

    logic        w_last;
    logic        w_acc_en;
    logic [3:0]  w_inc;
    logic [1:0]  w_best_idx;
    logic [14:0] w_best_val;

    assign w_last = (r_x == XL) && (r_y == YL);

    // The first SCAN cycle has no read data yet; DRAIN catches the
    // data belonging to the final address.
    assign w_acc_en = ((r_state == S_SCAN) && !r_skip) ||
                      (r_state == S_DRAIN);

    // State register
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_state_next = S_SCAN;
                end
            end
            S_SCAN: begin
                if (w_last) begin
                    w_state_next = S_DRAIN;
                end
            end
            S_DRAIN:   w_state_next = S_PUBLISH;
            S_PUBLISH: w_state_next = S_IDLE;
            default:   w_state_next = S_IDLE;
        endcase
    end

    // Colour decode: one-hot increment for the owning player.
    always_comb begin
        w_inc = 4'b0000;
        case (bus.rd_q)
            3'b001:  w_inc[0] = 1'b1;
            3'b010:  w_inc[1] = 1'b1;
            3'b100:  w_inc[2] = 1'b1;
            3'b110:  w_inc[3] = 1'b1;
            default: w_inc = 4'b0000;
        endcase
    end

    // Strictly-greater comparison keeps the lowest index on ties.
    always_comb begin
        w_best_idx = 2'd0;
        w_best_val = r_acc[0];
        for (int i = 1; i < 4; i++) begin
            if (r_acc[i] > w_best_val) begin
                w_best_val = r_acc[i];
                w_best_idx = 2'(i);
            end
        end
    end

    // Datapath: address walker, accumulators, published results.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            r_x      <= 8'd0;
            r_y      <= 7'd0;
            r_skip   <= 1'b0;
            r_winner <= 2'd0;
            r_done   <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                r_acc[i] <= 15'd0;
                r_cnt[i] <= 15'd0;
            end
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_x    <= 8'd0;
                        r_y    <= 7'd0;
                        r_skip <= (RD_LATENCY != 0);
                        for (int i = 0; i < 4; i++) begin
                            r_acc[i] <= 15'd0;
                        end
                    end
                end
                S_SCAN: begin
                    r_skip <= 1'b0;
                    // Address holds at the last cell once issued.
                    if (!w_last) begin
                        if (r_y == YL) begin
                            r_y <= 7'd0;
                            r_x <= r_x + 8'd1;
                        end else begin
                            r_y <= r_y + 7'd1;
                        end
                    end
                end
                S_PUBLISH: begin
                    for (int i = 0; i < 4; i++) begin
                        r_cnt[i] <= r_acc[i];
                    end
                    r_winner <= w_best_idx;
                    r_done   <= 1'b1;
                end
                default: begin
                end
            endcase
            if (w_acc_en) begin
                for (int i = 0; i < 4; i++) begin
                    r_acc[i] <= r_acc[i] + {14'd0, w_inc[i]};
                end
            end
        end
    end

    assign bus.rd_address = {r_x, r_y};
    assign bus.busy       = (r_state != S_IDLE);
    assign bus.done       = r_done;

    assign p1_count = r_cnt[0];
    assign p2_count = r_cnt[1];
    assign p3_count = r_cnt[2];
    assign p4_count = r_cnt[3];
    assign winner   = r_winner;

endmodule

// File: tb/tb_territory_scanner.sv
// tb_territory_scanner: random and patterned RAM images swept by the
// scanner, checked against a cell-counting reference model.
module tb_territory_scanner;

    localparam int NCELL = 19200;
    localparam int SCAN_CYC = 19202;

    logic        CLOCK_50;
    logic        resetn;
    logic [14:0] p1_count;
    logic [14:0] p2_count;
    logic [14:0] p3_count;
    logic [14:0] p4_count;
    logic [1:0]  winner;

    territory_scanner_if bus ();

    territory_scanner #(
        .X_MAX      (159),
        .Y_MAX      (119),
        .RD_LATENCY (1)
    ) dut (
        .CLOCK_50 (CLOCK_50),
        .resetn   (resetn),
        .bus      (bus.master),
        .p1_count (p1_count),
        .p2_count (p2_count),
        .p3_count (p3_count),
        .p4_count (p4_count),
        .winner   (winner)
    );

    initial CLOCK_50 = 1'b0;
    always #5 CLOCK_50 = ~CLOCK_50;

    // Territory RAM: registered address, one-cycle read.
    logic [2:0] mem [32768];
    always @(posedge CLOCK_50) bus.rd_q <= mem[bus.rd_address];

    int n_cmp = 0;
    int n_bad = 0;
    int exp_c [4];
    int exp_w;
    int seen [NCELL];

    task automatic chk(input string tag, input longint got,
                       input longint want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, want);
        end
    endtask

    function automatic int aidx(input int x, input int y);
        return x * 128 + y;
    endfunction

    // Rows 120..127 hold an owned colour so stray reads would be counted.
    task automatic fill_const(input logic [2:0] v);
        for (int a = 0; a < 32768; a++) begin
            mem[a] = ((a % 128) >= 120) ? 3'b001 : v;
        end
    endtask

    task automatic fill_cols();
        fill_const(3'b111);
        for (int y = 0; y < 120; y++) begin
            mem[aidx(0, y)] = 3'b001;
            mem[aidx(1, y)] = 3'b010;
            mem[aidx(2, y)] = 3'b010;
            mem[aidx(3, y)] = 3'b110;
        end
    endtask

    task automatic fill_rand();
        fill_const(3'b000);
        for (int x = 0; x < 160; x++) begin
            for (int y = 0; y < 120; y++) begin
                mem[aidx(x, y)] = 3'($urandom_range(0, 7));
            end
        end
    endtask

    // 500 cells each of p2 and p4 at random spots, the rest unowned codes.
    task automatic fill_tie();
        logic [2:0] nocode [4];
        int placed;
        int c;
        nocode[0] = 3'b000;
        nocode[1] = 3'b011;
        nocode[2] = 3'b101;
        nocode[3] = 3'b111;
        fill_const(3'b000);
        for (int x = 0; x < 160; x++) begin
            for (int y = 0; y < 120; y++) begin
                mem[aidx(x, y)] = nocode[$urandom_range(0, 3)];
            end
        end
        for (int k = 0; k < 2; k++) begin
            placed = 0;
            while (placed < 500) begin
                c = $urandom_range(0, NCELL - 1);
                if (mem[aidx(c / 120, c % 120)] != 3'b010 &&
                    mem[aidx(c / 120, c % 120)] != 3'b110) begin
                    mem[aidx(c / 120, c % 120)] = (k == 0) ? 3'b010
                                                           : 3'b110;
                    placed++;
                end
            end
        end
    endtask

    // Reference: count owned cells over the playfield, pick the leader.
    task automatic model();
        for (int i = 0; i < 4; i++) exp_c[i] = 0;
        for (int x = 0; x < 160; x++) begin
            for (int y = 0; y < 120; y++) begin
                case (mem[aidx(x, y)])
                    3'b001:  exp_c[0]++;
                    3'b010:  exp_c[1]++;
                    3'b100:  exp_c[2]++;
                    3'b110:  exp_c[3]++;
                    default: ;
                endcase
            end
        end
        exp_w = 0;
        for (int i = 1; i < 4; i++) begin
            if (exp_c[i] > exp_c[exp_w]) exp_w = i;
        end
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, "_busy"}, bus.busy, 0);
        chk({nm, "_done"}, bus.done, 0);
        chk({nm, "_addr"}, bus.rd_address, 0);
        chk({nm, "_p1"}, p1_count, 0);
        chk({nm, "_p2"}, p2_count, 0);
        chk({nm, "_p3"}, p3_count, 0);
        chk({nm, "_p4"}, p4_count, 0);
        chk({nm, "_win"}, winner, 0);
    endtask

    // Called at a negedge: raises start for the next edge (E0), then
    // observes every negedge n (state after edge E0+n).
    task automatic scan(input string nm, input int ign_at,
                        input int abort_at);
        int n;
        int busy_cnt;
        int done_at;
        int ord_err;
        int yr_err;
        int cov_err;
        bit got_done;
        logic [14:0] ea;
        model();
        foreach (seen[i]) seen[i] = 0;
        n = 0;
        busy_cnt = 0;
        done_at = -1;
        ord_err = 0;
        yr_err = 0;
        cov_err = 0;
        got_done = 0;
        bus.start = 1'b1;
        @(posedge CLOCK_50);
        @(negedge CLOCK_50);
        while (n < SCAN_CYC + 100) begin
            bus.start = (n == ign_at);
            if (abort_at >= 0 && n == abort_at) begin
                resetn = 1'b0;
                #1;
                chk_zero({nm, "_rst"});
                for (int k = 0; k < 3; k++) begin
                    @(negedge CLOCK_50);
                    chk({nm, "_rst_nodone"}, bus.done, 0);
                end
                resetn = 1'b1;
                for (int k = 0; k < 3; k++) begin
                    @(negedge CLOCK_50);
                    chk({nm, "_post_idle"}, bus.busy | bus.done, 0);
                end
                return;
            end
            if (bus.busy) busy_cnt++;
            if (n < NCELL) begin
                ea = {8'(n / 120), 7'(n % 120)};
                if (bus.rd_address !== ea) ord_err++;
                if (bus.rd_address[6:0] > 7'd119 ||
                    bus.rd_address[14:7] > 8'd159) begin
                    yr_err++;
                end else begin
                    seen[int'(bus.rd_address[14:7]) * 120 +
                         int'(bus.rd_address[6:0])]++;
                end
            end
            if (bus.done) begin
                got_done = 1;
                done_at = n;
                break;
            end
            @(negedge CLOCK_50);
            n++;
        end
        bus.start = 1'b0;
        if (abort_at >= 0) begin
            chk({nm, "_done_before_abort"}, got_done, 0);
            return;
        end
        chk({nm, "_done_seen"}, got_done, 1);
        chk({nm, "_done_at"}, done_at, SCAN_CYC);
        chk({nm, "_busy_cycles"}, busy_cnt, SCAN_CYC);
        chk({nm, "_busy_at_done"}, bus.busy, 0);
        chk({nm, "_addr_order"}, ord_err, 0);
        chk({nm, "_addr_range"}, yr_err, 0);
        foreach (seen[i]) if (seen[i] != 1) cov_err++;
        chk({nm, "_addr_once"}, cov_err, 0);
        chk({nm, "_addr_hold"}, bus.rd_address, {8'd159, 7'd119});
        chk({nm, "_p1"}, p1_count, exp_c[0]);
        chk({nm, "_p2"}, p2_count, exp_c[1]);
        chk({nm, "_p3"}, p3_count, exp_c[2]);
        chk({nm, "_p4"}, p4_count, exp_c[3]);
        chk({nm, "_win"}, winner, exp_w);
    endtask

    initial begin
        resetn = 1'b0;
        bus.start = 1'b0;
        fill_const(3'b000);
        repeat (3) @(negedge CLOCK_50);
        chk_zero("reset");
        resetn = 1'b1;
        repeat (2) @(negedge CLOCK_50);

        // Stray start at E0+100 must be ignored.
        scan("zero", 100, -1);

        // Launched by a start held during the previous done cycle.
        fill_const(3'b100);
        scan("p3", -1, -1);

        fill_cols();
        repeat (3) @(negedge CLOCK_50);
        scan("cols", -1, -1);

        fill_rand();
        repeat (2) @(negedge CLOCK_50);
        scan("abort", -1, 5000);

        fill_tie();
        scan("tie", -1, -1);
        @(negedge CLOCK_50);
        chk("tie_done_width", bus.done, 0);
        chk("tie_idle", bus.busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
